// File: rtl/binary_gray_conv.sv
// Registered binary<->Gray converter with a per-transfer direction select and one cycle of latency.
// Defining BINARY_GRAY_ADJ_CHECK_EN adds adj_ok, which flags single-bit steps between successive Gray words.
module binary_gray_conv #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             mode,
    input  logic [WIDTH-1:0] din,
    output logic             out_valid,
    output logic [WIDTH-1:0] dout,
`ifdef BINARY_GRAY_ADJ_CHECK_EN
    output logic             adj_ok,
`endif
    output logic             dout_mode
);

    logic [WIDTH-1:0] b2g;
    logic [WIDTH-1:0] g2b;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_mode_q, dout_mode_d;

    // Gray->binary bit i is the XOR of all Gray bits from i up to the MSB.
    always_comb begin
        b2g = din ^ (din >> 1);
        g2b = '0;
        for (int i = 0; i < WIDTH; i++) begin
            g2b[i] = ^(din >> i);
        end
    end

    always_comb begin
        out_valid_d = in_valid;
        dout_d      = dout_q;
        dout_mode_d = dout_mode_q;
        if (in_valid) begin
            dout_d      = mode ? g2b : b2g;
            dout_mode_d = mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            dout_mode_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            dout_mode_q <= dout_mode_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign dout_mode = dout_mode_q;

`ifdef BINARY_GRAY_ADJ_CHECK_EN
    logic [WIDTH-1:0] gray_cur;
    logic [WIDTH-1:0] gray_diff;
    logic             one_bit_step;
    logic [WIDTH-1:0] hist_q, hist_d;
    logic             hist_valid_q, hist_valid_d;
    logic             adj_ok_q, adj_ok_d;

    // The Gray-domain word is the output in binary->Gray mode and the input in Gray->binary mode.
    always_comb begin
        gray_cur     = mode ? din : b2g;
        gray_diff    = gray_cur ^ hist_q;
        one_bit_step = (gray_diff != '0) && ((gray_diff & (gray_diff - WIDTH'(1))) == '0);
        hist_d       = hist_q;
        hist_valid_d = hist_valid_q;
        adj_ok_d     = adj_ok_q;
        if (in_valid) begin
            hist_d       = gray_cur;
            hist_valid_d = 1'b1;
            adj_ok_d     = hist_valid_q ? one_bit_step : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q       <= '0;
            hist_valid_q <= 1'b0;
            adj_ok_q     <= 1'b0;
        end else begin
            hist_q       <= hist_d;
            hist_valid_q <= hist_valid_d;
            adj_ok_q     <= adj_ok_d;
        end
    end

    assign adj_ok = adj_ok_q;
`endif

endmodule

// File: tb/tb_binary_gray_conv.sv
// Directed bench for binary_gray_conv: reset, both directions, boundaries, mode interleave, hold, mid-stream reset.
// With BINARY_GRAY_ADJ_CHECK_EN defined it also checks adj_ok over a binary sweep and hand-picked Gray steps.
module tb_binary_gray_conv;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         mode;
    logic [W-1:0] din;
    logic         out_valid;
    logic [W-1:0] dout;
    logic         dout_mode;
`ifdef BINARY_GRAY_ADJ_CHECK_EN
    logic         adj_ok;
`endif

    int errors = 0;
    int checks = 0;

    binary_gray_conv #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .mode      (mode),
        .din       (din),
        .out_valid (out_valid),
        .dout      (dout),
`ifdef BINARY_GRAY_ADJ_CHECK_EN
        .adj_ok    (adj_ok),
`endif
        .dout_mode (dout_mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample #1 after the capturing edge.
    task automatic drive(input logic r, input logic v, input logic m, input logic [W-1:0] d);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        mode     = m;
        din      = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic v, input logic m, input logic [W-1:0] d,
                        input logic ev, input logic [W-1:0] ed, input logic em);
        drive(1'b0, v, m, d);
        check({tag, ".valid"}, 32'(out_valid), 32'(ev));
        check({tag, ".dout"},  32'(dout),      32'(ed));
        check({tag, ".mode"},  32'(dout_mode), 32'(em));
    endtask

    // Bit-by-bit reflected Gray encoding used for the sweep expectations.
    function automatic logic [W-1:0] gray_of(input logic [W-1:0] b);
        logic [W-1:0] g;
        g[W-1] = b[W-1];
        for (int i = 0; i < W - 1; i++) g[i] = b[i+1] ^ b[i];
        return g;
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b1; mode = 1'b1; din = 4'b1111;

        // Reset held two cycles while in_valid is high: reset must win.
        drive(1'b1, 1'b1, 1'b1, 4'b1111);
        drive(1'b1, 1'b1, 1'b1, 4'b1111);
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.dout",  32'(dout),      32'd0);
        check("rst.mode",  32'(dout_mode), 32'd0);
        step("idle0", 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        step("b2g_1001", 1'b1, 1'b0, 4'b1001, 1'b1, 4'b1101, 1'b0);
        step("b2g_1101", 1'b1, 1'b0, 4'b1101, 1'b1, 4'b1011, 1'b0);
        step("g2b_1101", 1'b1, 1'b1, 4'b1101, 1'b1, 4'b1001, 1'b1);
        step("g2b_1011", 1'b1, 1'b1, 4'b1011, 1'b1, 4'b1101, 1'b1);

        step("b2g_0000", 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
        step("b2g_1111", 1'b1, 1'b0, 4'b1111, 1'b1, 4'b1000, 1'b0);
        step("g2b_1000", 1'b1, 1'b1, 4'b1000, 1'b1, 4'b1111, 1'b1);
        step("g2b_0000", 1'b1, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1);

        step("alt_b_0110", 1'b1, 1'b0, 4'b0110, 1'b1, 4'b0101, 1'b0);
        step("alt_g_0110", 1'b1, 1'b1, 4'b0110, 1'b1, 4'b0100, 1'b1);
        step("alt_b_1010", 1'b1, 1'b0, 4'b1010, 1'b1, 4'b1111, 1'b0);
        step("alt_g_0011", 1'b1, 1'b1, 4'b0011, 1'b1, 4'b0010, 1'b1);
        step("hold1", 1'b0, 1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1);
        step("hold2", 1'b0, 1'b0, 4'b0101, 1'b0, 4'b0010, 1'b1);

        // Reset in the middle of a stream drops the in-flight word.
        step("pre_rst", 1'b1, 1'b1, 4'b0111, 1'b1, 4'b0101, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 4'b0100);
        check("mid_rst.valid", 32'(out_valid), 32'd0);
        check("mid_rst.dout",  32'(dout),      32'd0);
        check("mid_rst.mode",  32'(dout_mode), 32'd0);
        step("post_rst_idle", 1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0);
        step("post_rst_b2g",  1'b1, 1'b0, 4'b0011, 1'b1, 4'b0010, 1'b0);

        // Fresh reset so the adjacency history starts empty for the sweep.
        drive(1'b1, 1'b0, 1'b0, 4'b0000);
`ifdef BINARY_GRAY_ADJ_CHECK_EN
        check("adj.rst", 32'(adj_ok), 32'd0);
`endif
        for (int b = 0; b < 16; b++) begin
            step($sformatf("sweep_%0d", b), 1'b1, 1'b0, W'(b), 1'b1, gray_of(W'(b)), 1'b0);
`ifdef BINARY_GRAY_ADJ_CHECK_EN
            check($sformatf("adj.sweep_%0d", b), 32'(adj_ok), 32'd1);
`endif
        end
        step("wrap_0", 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0);
`ifdef BINARY_GRAY_ADJ_CHECK_EN
        check("adj.wrap", 32'(adj_ok), 32'd1);
`endif
        step("jump_0101", 1'b1, 1'b0, 4'b0101, 1'b1, 4'b0111, 1'b0);
`ifdef BINARY_GRAY_ADJ_CHECK_EN
        check("adj.jump", 32'(adj_ok), 32'd0);
`endif
        // Gray-domain word now comes from din: 0111 -> 0110 is one bit, then a repeat is not.
        step("g_step_0110", 1'b1, 1'b1, 4'b0110, 1'b1, 4'b0100, 1'b1);
`ifdef BINARY_GRAY_ADJ_CHECK_EN
        check("adj.g_step", 32'(adj_ok), 32'd1);
`endif
        step("g_same_0110", 1'b1, 1'b1, 4'b0110, 1'b1, 4'b0100, 1'b1);
`ifdef BINARY_GRAY_ADJ_CHECK_EN
        check("adj.g_same", 32'(adj_ok), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
